// File: rtl/wb_test_slave_regs.sv
// Classic Wishbone register-file responder with programmable wait states,
// byte-lane writes and access counters for bench self-checks.
module wb_test_slave_regs #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_ADDR_BITS = 4,
  parameter int unsigned WAIT_STATES   = 0,
  parameter logic [31:0] DEAD_VALUE    = 32'hDEADBEEF
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst_n,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_addr_i,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic                    wb_ack_o,
  output logic [15:0]             wr_count_o,
  output logic [15:0]             rd_count_o,
  output logic [15:0]             err_count_o
);

  localparam int unsigned NUM_REGS  = 1 << REG_ADDR_BITS;
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = 4;
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD =
    NO_WAIT ? '0 : CNT_WIDTH'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                   state;
  logic [CNT_WIDTH-1:0]     wait_cnt;
  logic [DATA_WIDTH-1:0]    regs [NUM_REGS];

  logic                     req_c;
  logic                     in_range_c;
  logic [REG_ADDR_BITS-1:0] idx_c;
  logic [DATA_WIDTH-1:0]    wr_mask_c;
  logic                     commit_c;

  // Request decode, range check and register index
  always_comb begin
    req_c      = wb_cyc_i & wb_stb_i;
    in_range_c = (wb_addr_i[ADDR_WIDTH-1:REG_ADDR_BITS] == '0);
    idx_c      = wb_addr_i[REG_ADDR_BITS-1:0];
  end

  // Expand byte-lane selects into a bit mask
  always_comb begin
    wr_mask_c = '0;
    for (int i = 0; i < int'(SEL_WIDTH); i++) begin
      wr_mask_c[8*i +: 8] = {8{wb_sel_i[i]}};
    end
  end

  // The access completes at the edge that moves the FSM into ACK
  always_comb begin
    commit_c = 1'b0;
    if (req_c) begin
      if (state == IDLE && NO_WAIT) begin
        commit_c = 1'b1;
      end else if (state == WAIT && wait_cnt == '0) begin
        commit_c = 1'b1;
      end
    end
  end

  // Handshake FSM, register file, read data and counters
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      wb_ack_o    <= 1'b0;
      wb_data_o   <= '0;
      wr_count_o  <= '0;
      rd_count_o  <= '0;
      err_count_o <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;

      case (state)
        IDLE: begin
          if (req_c && !NO_WAIT) begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!req_c) begin
            state <= IDLE;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_WIDTH'(1);
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (commit_c) begin
        state    <= ACK;
        wb_ack_o <= 1'b1;
        if (in_range_c) begin
          if (wb_we_i) begin
            regs[idx_c] <= (regs[idx_c] & ~wr_mask_c) | (wb_data_i & wr_mask_c);
            wr_count_o  <= wr_count_o + 16'd1;
          end else begin
            wb_data_o  <= regs[idx_c];
            rd_count_o <= rd_count_o + 16'd1;
          end
        end else begin
          err_count_o <= err_count_o + 16'd1;
          if (!wb_we_i) begin
            wb_data_o <= DATA_WIDTH'(DEAD_VALUE);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_test_slave_regs.sv
// Bench for wb_test_slave_regs: one instance with no wait states and one
// with three, driven by directed and random accesses against a word-array model.
module tb_wb_test_slave_regs;

  logic        clk;
  logic        rst0_n, rst3_n;
  logic        cyc0, cyc3, stb, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic [31:0] dout0, dout3;
  logic        ack0, ack3;
  logic [15:0] wrc0, rdc0, errc0, wrc3, rdc3, errc3;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: register contents and access counts per instance
  logic [31:0] mdl [2][16];
  int          mwr [2];
  int          mrd [2];
  int          merr[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_test_slave_regs #(.WAIT_STATES(0)) dut0 (
    .wb_clk(clk), .wb_rst_n(rst0_n), .wb_cyc_i(cyc0), .wb_stb_i(stb),
    .wb_we_i(we), .wb_addr_i(addr), .wb_data_i(wdata), .wb_sel_i(sel),
    .wb_data_o(dout0), .wb_ack_o(ack0),
    .wr_count_o(wrc0), .rd_count_o(rdc0), .err_count_o(errc0)
  );

  wb_test_slave_regs #(.WAIT_STATES(3)) dut3 (
    .wb_clk(clk), .wb_rst_n(rst3_n), .wb_cyc_i(cyc3), .wb_stb_i(stb),
    .wb_we_i(we), .wb_addr_i(addr), .wb_data_i(wdata), .wb_sel_i(sel),
    .wb_data_o(dout3), .wb_ack_o(ack3),
    .wr_count_o(wrc3), .rd_count_o(rdc3), .err_count_o(errc3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ack(input int d);
    return (d == 0) ? ack0 : ack3;
  endfunction

  function automatic logic [31:0] get_dout(input int d);
    return (d == 0) ? dout0 : dout3;
  endfunction

  function automatic int wait_states(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic model_reset(input int d);
    for (int i = 0; i < 16; i++) mdl[d][i] = 32'h0;
    mwr[d] = 0; mrd[d] = 0; merr[d] = 0;
  endtask

  task automatic check_counters(input int d, input string tag);
    if (d == 0) begin
      check({tag, "_wr"},  {16'h0, wrc0},  32'(16'(mwr[0])));
      check({tag, "_rd"},  {16'h0, rdc0},  32'(16'(mrd[0])));
      check({tag, "_err"}, {16'h0, errc0}, 32'(16'(merr[0])));
    end else begin
      check({tag, "_wr"},  {16'h0, wrc3},  32'(16'(mwr[1])));
      check({tag, "_rd"},  {16'h0, rdc3},  32'(16'(mrd[1])));
      check({tag, "_err"}, {16'h0, errc3}, 32'(16'(merr[1])));
    end
  endtask

  task automatic set_cyc(input int d, input logic v);
    if (d == 0) cyc0 = v; else cyc3 = v;
  endtask

  // One full access; called at a negedge, returns at a negedge after ack drops
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] s,
                        output logic [31:0] rdata);
    int edges;
    int m;
    logic [31:0] exp;
    m = (d == 0) ? 0 : 1;
    we = w; addr = a; wdata = dat; sel = s; stb = 1'b1;
    set_cyc(d, 1'b1);
    edges = 0;
    do begin
      @(posedge clk); @(negedge clk);
      edges++;
    end while (!get_ack(d) && edges < 20);
    check("ack_latency", 32'(edges), 32'(wait_states(d) + 1));
    rdata = get_dout(d);
    exp = 32'h0;
    if (a < 32'd16) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) mdl[m][a[3:0]][8*i +: 8] = dat[8*i +: 8];
        mwr[m]++;
      end else begin
        exp = mdl[m][a[3:0]];
        mrd[m]++;
      end
    end else begin
      if (!w) exp = 32'hDEADBEEF;
      merr[m]++;
    end
    if (!w) check("read_data", rdata, exp);
    stb = 1'b0;
    set_cyc(d, 1'b0);
    @(posedge clk); @(negedge clk);
    check("ack_single", {31'h0, get_ack(d)}, 32'h0);
    check("dout_idle", get_dout(d), 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] ra;
    logic        stray_ack;

    cyc0 = 0; cyc3 = 0; stb = 0; we = 0; addr = 0; wdata = 0; sel = 0;
    rst0_n = 0; rst3_n = 0;
    model_reset(0); model_reset(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack0", {31'h0, ack0}, 32'h0);
    check("rst_dout0", dout0, 32'h0);
    check("rst_ack3", {31'h0, ack3}, 32'h0);
    check_counters(0, "rst0");
    check_counters(1, "rst3");
    rst0_n = 1; rst3_n = 1;
    @(negedge clk);

    access(0, 1'b0, 32'h0, 32'h0, 4'h0, rd);
    check("rst_read0", rd, 32'h0);

    // Full-word write and readback, no wait states
    access(0, 1'b1, 32'h1, 32'hCAFEF00D, 4'hF, rd);
    access(0, 1'b0, 32'h1, 32'h0, 4'h0, rd);
    check("w32_read", rd, 32'hCAFEF00D);
    check("w32_wrc", {16'h0, wrc0}, 32'd1);
    check("w32_rdc", {16'h0, rdc0}, 32'd2);

    // Byte lanes
    access(0, 1'b1, 32'h2, 32'h11223344, 4'hF, rd);
    access(0, 1'b1, 32'h2, 32'hAA000000, 4'b1000, rd);
    access(0, 1'b1, 32'h2, 32'h0000BBCC, 4'b0011, rd);
    access(0, 1'b1, 32'h2, 32'h99999999, 4'b0000, rd);
    access(0, 1'b0, 32'h2, 32'h0, 4'h0, rd);
    check("lanes", rd, 32'hAA22BBCC);
    check_counters(0, "lanes");

    // Out of range
    access(0, 1'b1, 32'h10, 32'h55, 4'hF, rd);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    check("oor_dead", rd, 32'hDEADBEEF);
    check("oor_errc", {16'h0, errc0}, 32'd2);
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, rd);
    check("oor_reg0", rd, 32'h0);
    check_counters(0, "oor");

    // Three wait states: normal read, then an aborted request
    access(1, 1'b1, 32'h7, 32'h12345678, 4'hF, rd);
    access(1, 1'b0, 32'h7, 32'h0, 4'h0, rd);
    check("ws3_read", rd, 32'h12345678);
    we = 1'b1; addr = 32'h7; wdata = 32'hFFFFFFFF; sel = 4'hF; stb = 1'b1; cyc3 = 1'b1;
    stray_ack = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); stray_ack |= ack3; end
    stb = 1'b0; cyc3 = 1'b0;
    repeat (5) begin @(posedge clk); @(negedge clk); stray_ack |= ack3; end
    check("abort_noack", {31'h0, stray_ack}, 32'h0);
    check_counters(1, "abort");
    access(1, 1'b0, 32'h7, 32'h0, 4'h0, rd);
    check("abort_keep", rd, 32'h12345678);

    // Asynchronous reset while a write is waiting
    we = 1'b1; addr = 32'h5; wdata = 32'hA5A5A5A5; sel = 4'hF; stb = 1'b1; cyc3 = 1'b1;
    stray_ack = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); stray_ack |= ack3; end
    rst3_n = 1'b0;
    #1;
    stb = 1'b0; cyc3 = 1'b0;
    model_reset(1);
    repeat (2) begin @(posedge clk); @(negedge clk); stray_ack |= ack3; end
    rst3_n = 1'b1;
    repeat (4) begin @(posedge clk); @(negedge clk); stray_ack |= ack3; end
    check("rst_mid_noack", {31'h0, stray_ack}, 32'h0);
    check_counters(1, "rst_mid");
    access(1, 1'b0, 32'h5, 32'h0, 4'h0, rd);
    check("rst_mid_reg", rd, 32'h0);

    // Random traffic on both instances
    for (int k = 0; k < 80; k++) begin
      int d;
      d = (k % 2 == 0) ? 0 : 1;
      if ($urandom_range(0, 7) == 0) ra = $urandom | 32'h10;
      else ra = 32'($urandom_range(0, 15));
      access(d, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)), rd);
    end
    check_counters(0, "rand0");
    check_counters(1, "rand3");
    for (int i = 0; i < 16; i++) begin
      access(0, 1'b0, 32'(i), 32'h0, 4'h0, rd);
      access(1, 1'b0, 32'(i), 32'h0, 4'h0, rd);
    end
    check_counters(0, "final0");
    check_counters(1, "final3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
